// File: rtl/pds_rx_port_if.sv
// Byte-stream bundle for the packet receive port: inbound bytes from the link,
// outbound bytes to the consumer.
interface pds_rx_port_if;
  logic       in_valid;
  logic       in_sop;
  logic       in_eop;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_eop;

  modport master (
    output in_valid, in_sop, in_eop, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sop, out_eop
  );

  modport slave (
    input  in_valid, in_sop, in_eop, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sop, out_eop
  );
endinterface

// File: rtl/pds_rx_port.sv
// Packet receiver: filters inbound packets by port number and length, stores
// them tentatively, and publishes only complete, well-formed packets to the reader.
module pds_rx_port #(
  parameter logic [3:0] PORTNO = 4'd0,
  parameter int         DEPTH  = 32
) (
  input  logic          clock,
  input  logic          reset,
  pds_rx_port_if.slave  bus,
  output logic [15:0]   pkt_ok_cnt,
  output logic [15:0]   pkt_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [PW-1:0] ROOM_MIN = PW'(16);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STORE   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_wr_cmt;
  logic [PW-1:0] r_rd_ptr;
  logic [3:0]    r_rem;
  logic          r_run;
  logic [15:0]   r_ok_cnt;
  logic [15:0]   r_drop_cnt;
  logic [9:0]    r_mem [DEPTH];

  logic          w_accept;
  logic          w_good_hdr;
  logic          w_last;
  logic          w_bad_term;
  logic [PW-1:0] w_occ;
  logic [PW-1:0] w_free;
  logic          w_empty;
  logic          w_full;
  logic          w_in_ready;
  logic          w_read;
  logic [9:0]    w_head;

  logic          w_wr_en;
  logic          w_wr_sop;
  logic          w_commit;
  logic          w_rollback;
  logic          w_drop_inc;
  logic          w_ok_inc;
  logic          w_rem_load;

  // The reader only ever sees the committed write pointer.
  assign w_occ   = r_wr_cmt - r_rd_ptr;
  assign w_free  = DEPTH_P - w_occ;
  assign w_empty = (r_wr_cmt == r_rd_ptr);
  assign w_full  = (r_wr_cmt[AW] != r_rd_ptr[AW]) &&
                   (r_wr_cmt[AW-1:0] == r_rd_ptr[AW-1:0]);

  // Room for a maximum-size packet (header + 15 bytes) is checked only at packet start.
  assign w_in_ready = r_run && ((r_state != IDLE) || (!w_full && (w_free >= ROOM_MIN)));
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_read     = !w_empty && bus.out_ready;

  assign w_good_hdr = (bus.in_data[7:4] == PORTNO) && (bus.in_data[3:0] != 4'd0);
  assign w_last     = (r_rem == 4'd1);
  // Early eop, missing eop on the final byte, or a stray sop all abort the packet.
  assign w_bad_term = bus.in_sop || (bus.in_eop != w_last);

  assign w_head        = r_mem[r_rd_ptr[AW-1:0]];
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_empty ? 8'h00 : w_head[7:0];
  assign bus.out_eop   = w_empty ? 1'b0  : w_head[8];
  assign bus.out_sop   = w_empty ? 1'b0  : w_head[9];
  assign pkt_ok_cnt    = r_ok_cnt;
  assign pkt_drop_cnt  = r_drop_cnt;

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && bus.in_sop) begin
          if (w_good_hdr) begin
            w_state_nxt = STORE;
          end else if (bus.in_eop) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DISCARD;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      STORE: begin
        if (w_accept) begin
          if (w_bad_term) begin
            w_state_nxt = bus.in_eop ? IDLE : DISCARD;
          end else if (w_last) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = STORE;
          end
        end else begin
          w_state_nxt = STORE;
        end
      end
      DISCARD: begin
        if (w_accept && bus.in_eop) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DISCARD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM datapath controls
  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_sop   = 1'b0;
    w_commit   = 1'b0;
    w_rollback = 1'b0;
    w_drop_inc = 1'b0;
    w_ok_inc   = 1'b0;
    w_rem_load = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && bus.in_sop) begin
          if (w_good_hdr) begin
            w_wr_en    = 1'b1;
            w_wr_sop   = 1'b1;
            w_rem_load = 1'b1;
          end else begin
            w_drop_inc = 1'b1;
          end
        end else begin
          w_wr_en = 1'b0;
        end
      end
      STORE: begin
        if (w_accept) begin
          if (w_bad_term) begin
            w_rollback = 1'b1;
            w_drop_inc = 1'b1;
          end else begin
            w_wr_en  = 1'b1;
            w_commit = w_last;
            w_ok_inc = w_last;
          end
        end else begin
          w_wr_en = 1'b0;
        end
      end
      DISCARD: begin
        w_wr_en = 1'b0;
      end
      default: begin
        w_wr_en = 1'b0;
      end
    endcase
  end

  // Tentative/committed write pointers and read pointer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= {PW{1'b0}};
      r_wr_cmt <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
    end else begin
      if (w_rollback) begin
        r_wr_ptr <= r_wr_cmt;
      end else if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_commit) begin
        r_wr_cmt <= r_wr_ptr + PW'(1);
      end
      if (w_read) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Remaining payload bytes of the packet being stored
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rem <= 4'd0;
    end else if (w_rem_load) begin
      r_rem <= bus.in_data[3:0];
    end else if (w_wr_en) begin
      r_rem <= r_rem - 4'd1;
    end
  end

  // Saturating packet counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ok_cnt   <= 16'd0;
      r_drop_cnt <= 16'd0;
    end else begin
      if (w_ok_inc && (r_ok_cnt != 16'hFFFF)) begin
        r_ok_cnt <= r_ok_cnt + 16'd1;
      end
      if (w_drop_inc && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  // Holds in_ready low until the first edge after reset release
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // Storage array: {sop, eop, data}; contents need no reset, pointers gate visibility
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {w_wr_sop, w_commit, bus.in_data};
    end
  end

endmodule

// File: tb/tb_pds_rx_port.sv
// Scoreboard bench for pds_rx_port: drivers push expected output bytes,
// a negedge monitor pops and compares every outbound transfer.
module tb_pds_rx_port;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ok_cnt;
  logic [15:0] drop_cnt;
  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  int          pops_base;
  logic [9:0]  exp_q[$];
  logic [9:0]  mon_exp;

  pds_rx_port_if bus();

  pds_rx_port #(.PORTNO(4'd0), .DEPTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .pkt_ok_cnt  (ok_cnt),
    .pkt_drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer seen here completes on the following rising edge.
  always @(negedge clock) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual=%0h required=none",
                 {bus.out_sop, bus.out_eop, bus.out_data});
      end else begin
        mon_exp = exp_q.pop_front();
        chk("out_byte", {22'd0, bus.out_sop, bus.out_eop, bus.out_data}, {22'd0, mon_exp});
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    int n;
    bus.in_data  = d;
    bus.in_sop   = s;
    bus.in_eop   = e;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!bus.in_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  // Good packet for port 0: header {0,len}, payload base+1 .. base+len.
  task automatic send_good(input logic [3:0] len, input logic [7:0] base, input logic keep);
    logic [7:0] d;
    if (keep) exp_q.push_back({1'b1, 1'b0, 4'h0, len});
    send_byte({4'h0, len}, 1'b1, 1'b0);
    for (int i = 1; i <= int'(len); i++) begin
      d = base + 8'(i);
      if (keep) exp_q.push_back({1'b0, (i == int'(len)), d});
      send_byte(d, 1'b0, (i == int'(len)));
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 600; n++) begin
      @(posedge clock);
      #1;
      if (exp_q.size() == 0 && !bus.out_valid) break;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sop    = 1'b0;
    bus.in_eop    = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_sop_eop", {bus.out_sop, bus.out_eop}, 0);
    chk("rst_counters", {ok_cnt, drop_cnt}, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("ready_after_reset", bus.in_ready, 1);

    // Basic packet, held back to observe 1-cycle commit latency
    bus.out_ready = 1'b0;
    send_good(4'd3, 8'h10, 1'b1);
    chk("latency_valid", bus.out_valid, 1);
    chk("latency_head", {bus.out_sop, bus.out_eop, bus.out_data}, {2'b10, 8'h03});
    bus.out_ready = 1'b1;
    drain();
    chk("ok_after_basic", ok_cnt, 1);

    // Stray byte in IDLE, then wrong port
    send_byte(8'h77, 1'b0, 1'b0);
    chk("stray_no_drop", drop_cnt, 0);
    send_byte(8'h52, 1'b1, 1'b0);
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b0, 1'b1);
    chk("wrong_port_drop", drop_cnt, 1);
    chk("wrong_port_no_out", bus.out_valid, 0);
    send_good(4'd2, 8'h40, 1'b1);
    drain();
    chk("ok_after_wrong_port", ok_cnt, 2);

    // Early eop rollback
    send_byte(8'h04, 1'b1, 1'b0);
    send_byte(8'h66, 1'b0, 1'b0);
    send_byte(8'h77, 1'b0, 1'b1);
    chk("early_eop_drop", drop_cnt, 2);
    chk("early_eop_no_out", bus.out_valid, 0);
    // Zero length header with eop
    send_byte(8'h00, 1'b1, 1'b1);
    chk("zero_len_drop", drop_cnt, 3);
    // sop inside a packet, not reprocessed as a header
    send_byte(8'h03, 1'b1, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b1, 1'b0);
    send_byte(8'h03, 1'b0, 1'b1);
    chk("inner_sop_drop", drop_cnt, 4);
    // Missing eop on the last byte
    send_byte(8'h02, 1'b1, 1'b0);
    send_byte(8'h0A, 1'b0, 1'b0);
    send_byte(8'h0B, 1'b0, 1'b0);
    send_byte(8'h0C, 1'b0, 1'b1);
    chk("missing_eop_drop", drop_cnt, 5);
    send_good(4'd1, 8'h90, 1'b1);
    drain();
    chk("ok_after_errors", ok_cnt, 3);

    // Backpressure: two maximum-size packets fill DEPTH=32
    bus.out_ready = 1'b0;
    send_good(4'd15, 8'h00, 1'b1);
    chk("ready_half_full", bus.in_ready, 1);
    send_good(4'd15, 8'h20, 1'b1);
    chk("ready_full", bus.in_ready, 0);
    chk("valid_full", bus.out_valid, 1);
    pops_base = pops;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clock);
      #1;
      if (bus.in_ready) break;
    end
    chk("ready_restore_pops", pops - pops_base, 16);
    drain();
    chk("ok_after_full", ok_cnt, 5);

    // Reset mid-STORE discards committed and tentative data
    bus.out_ready = 1'b0;
    send_good(4'd2, 8'hB0, 1'b0);
    send_byte(8'h03, 1'b1, 1'b0);
    send_byte(8'hE1, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_out", {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data}, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_counters", {ok_cnt, drop_cnt}, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    chk("midrst_empty", bus.out_valid, 0);
    @(posedge clock);
    #1;
    chk("midrst_ready_back", bus.in_ready, 1);
    send_good(4'd2, 8'hC0, 1'b1);
    drain();
    chk("ok_after_midrst", ok_cnt, 1);

    // Back-to-back short packets wrap the pointers several times
    for (int i = 0; i < 45; i++) begin
      send_good(4'd1, 8'(i * 3), 1'b1);
    end
    drain();
    chk("ok_after_stream", ok_cnt, 46);
    chk("drop_after_stream", drop_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
